param_stack: RTL and testbench

//  Parametrised LIFO stack: the successor to the fixed 12-bit, 8-deep three-slice stack.

---
 rtl/param_stack.sv | 187 ++++++++++++++++++
 tb/tb_param_stack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised LIFO stack with status decode and sticky error flags
//
// Purpose:
//   LIFO stack of DEPTH entries, each DATA_W bits wide. Supports push, pop,
//   simultaneous push+pop (replace-top, or bypass when empty) and a registered
//   pop data port. Status outputs decode combinationally from the count register.
//   Rejected pushes/pops set sticky overflow/underflow flags, cleared by err_clr.
//
// Ports:
//   clk          in   1         clock, rising edge
//   reset        in   1         asynchronous active-high reset
//   pushenbl     in   1         push request
//   popenbl      in   1         pop request
//   pushdatain   in   DATA_W    data to push
//   err_clr      in   1         clears sticky overflow/underflow (set wins)
//   popdataout   out  DATA_W    popped data, registered, holds when pop_valid=0
//   pop_valid    out  1         popdataout updated this cycle
//   count        out  CW        number of entries held
//   stack_empty  out  1         count == 0
//   stack_full   out  1         count == DEPTH
//   almost_full  out  1         count >= AF_LEVEL
//   overflow     out  1         sticky: a push was rejected
//   underflow    out  1         sticky: a pop was rejected

module param_stack #(
  parameter int  DATA_W   = 12,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = 6,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pushenbl,
  input  logic              popenbl,
  input  logic [DATA_W-1:0] pushdatain,
  input  logic              err_clr,
  output logic [DATA_W-1:0] popdataout,
  output logic              pop_valid,
  output logic [CW-1:0]     count,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  // Address width for the storage array; DEPTH >= 2 so $clog2 is at least 1.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately not reset so it can map onto plain flops/LUT RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] popdata_q, popdata_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              is_empty, is_full;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     free_idx;
  logic [DATA_W-1:0] top_data;

  logic              do_push, do_pop, do_replace, do_bypass;
  logic              ovf_event, unf_event;
  logic              mem_we;
  logic [AW-1:0]     mem_widx;

  // ------------------------------------------------------------------
  // Status decode from the count register
  // ------------------------------------------------------------------
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Both indices are forced to 0 on the boundary case where they would be
  // meaningless, so a non-power-of-2 DEPTH never addresses past DEPTH-1.
  assign top_idx  = is_empty ? '0 : AW'(count_q - CW'(1));
  assign free_idx = is_full  ? '0 : AW'(count_q);
  assign top_data = mem_q[top_idx];

  // ------------------------------------------------------------------
  // Per-edge action decode
  // ------------------------------------------------------------------
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    do_bypass  = 1'b0;
    ovf_event  = 1'b0;
    unf_event  = 1'b0;

    unique case ({pushenbl, popenbl})
      2'b10: begin
        do_push   = ~is_full;
        ovf_event = is_full;
      end
      2'b01: begin
        do_pop    = ~is_empty;
        unf_event = is_empty;
      end
      2'b11: begin
        // Replace-top is legal when full; bypass is legal when empty.
        do_replace = ~is_empty;
        do_bypass  = is_empty;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    count_d     = count_q;
    popdata_d   = popdata_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_widx    = free_idx;

    if (do_push) begin
      mem_we   = 1'b1;
      mem_widx = free_idx;
      count_d  = count_q + CW'(1);
    end

    if (do_pop) begin
      popdata_d   = top_data;
      pop_valid_d = 1'b1;
      count_d     = count_q - CW'(1);
    end

    if (do_replace) begin
      // Old top leaves through the pop port while the new word overwrites it.
      popdata_d   = top_data;
      pop_valid_d = 1'b1;
      mem_we      = 1'b1;
      mem_widx    = top_idx;
    end

    if (do_bypass) begin
      popdata_d   = pushdatain;
      pop_valid_d = 1'b1;
    end

    // Clear first, then let a same-edge event re-set the flag.
    overflow_d  = (overflow_q  & ~err_clr) | ovf_event;
    underflow_d = (underflow_q & ~err_clr) | unf_event;
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      popdata_q   <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      popdata_q   <= popdata_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= pushdatain;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign popdataout  = popdata_q;
  assign pop_valid   = pop_valid_q;
  assign count       = count_q;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - directed self-checking bench for param_stack

module tb_param_stack;

  localparam int DATA_W   = 12;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int CW       = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              pushenbl;
  logic              popenbl;
  logic [DATA_W-1:0] pushdatain;
  logic              err_clr;
  logic [DATA_W-1:0] popdataout;
  logic              pop_valid;
  logic [CW-1:0]     count;
  logic              stack_empty;
  logic              stack_full;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  int checks;
  int errors;

  param_stack #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pushenbl   (pushenbl),
    .popenbl    (popenbl),
    .pushdatain (pushdatain),
    .err_clr    (err_clr),
    .popdataout (popdataout),
    .pop_valid  (pop_valid),
    .count      (count),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs from a negedge, return at the next negedge.
  task automatic step(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic ec);
    pushenbl   = p;
    popenbl    = q;
    pushdatain = d;
    err_clr    = ec;
    @(posedge clk);
    @(negedge clk);
    pushenbl   = 1'b0;
    popenbl    = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({stack_empty, stack_full, almost_full} !== 3'b100) begin errors++; $display("FAIL reset_status got %b want 100", {stack_empty, stack_full, almost_full}); end
    checks++; if ({overflow, underflow, pop_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {overflow, underflow, pop_valid}); end
    checks++; if (popdataout !== 12'h000) begin errors++; $display("FAIL reset_popdata got %h want 000", popdataout); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lifo;
    logic [DATA_W-1:0] vals [3];
    vals[0] = 12'h111; vals[1] = 12'h222; vals[2] = 12'h333;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, vals[i], 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL lifo_count3 got %0d want 3", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL lifo_pv_push got %b want 0", pop_valid); end
    for (int i = 2; i >= 0; i--) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (popdataout !== vals[i] || pop_valid !== 1'b1) begin errors++; $display("FAIL lifo_pop%0d got %h/%b want %h/1", i, popdataout, pop_valid, vals[i]); end
      checks++; if (count !== CW'(i)) begin errors++; $display("FAIL lifo_count%0d got %0d want %0d", i, count, i); end
    end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++; if (pop_valid !== 1'b0 || popdataout !== 12'h111) begin errors++; $display("FAIL lifo_hold got %h/%b want 111/0", popdataout, pop_valid); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got %b want 1", stack_empty); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 12'h100 + 12'(i), 1'b0);
      checks++; if (almost_full !== (i + 1 >= AF_LEVEL)) begin errors++; $display("FAIL ovf_af_at%0d got %b", i + 1, almost_full); end
    end
    checks++; if (stack_full !== 1'b1 || overflow !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL ovf_full got full=%b ovf=%b cnt=%0d want 1/0/8", stack_full, overflow, count); end
    step(1'b1, 1'b0, 12'hABC, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 4'd8 || stack_full !== 1'b1) begin errors++; $display("FAIL ovf_reject got ovf=%b cnt=%0d full=%b want 1/8/1", overflow, count, stack_full); end
    // err_clr together with a new rejected push: flag must stay set
    step(1'b1, 1'b0, 12'hABC, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (popdataout !== 12'h107 || count !== 4'd7) begin errors++; $display("FAIL ovf_pop got %h cnt=%0d want 107 cnt=7", popdataout, count); end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (popdataout !== 12'h100 || stack_empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL ovf_drain got %h empty=%b unf=%b want 100/1/0", popdataout, stack_empty, underflow); end
  endtask

  task automatic test_underflow;
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (underflow !== 1'b1 || pop_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL unf_set got unf=%b pv=%b cnt=%0d want 1/0/0", underflow, pop_valid, count); end
    step(1'b0, 1'b1, '0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set_wins got %b want 1", underflow); end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow); end
  endtask

  task automatic test_replace;
    step(1'b1, 1'b0, 12'h011, 1'b0);
    step(1'b1, 1'b0, 12'h0AA, 1'b0);
    step(1'b1, 1'b1, 12'h0BB, 1'b0);
    checks++; if (popdataout !== 12'h0AA || pop_valid !== 1'b1 || count !== 4'd2) begin errors++; $display("FAIL repl_top got %h pv=%b cnt=%0d want 0aa/1/2", popdataout, pop_valid, count); end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (popdataout !== 12'h0BB) begin errors++; $display("FAIL repl_next got %h want 0bb", popdataout); end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (popdataout !== 12'h011 || count !== 4'd0) begin errors++; $display("FAIL repl_bottom got %h cnt=%0d want 011/0", popdataout, count); end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 12'h200 + 12'(i), 1'b0);
    step(1'b1, 1'b1, 12'h3CC, 1'b0);
    checks++; if (popdataout !== 12'h207 || count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL repl_full got %h cnt=%0d ovf=%b want 207/8/0", popdataout, count, overflow); end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (popdataout !== 12'h3CC) begin errors++; $display("FAIL repl_full_next got %h want 3cc", popdataout); end
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (popdataout !== 12'h200 || stack_empty !== 1'b1) begin errors++; $display("FAIL repl_drain got %h empty=%b want 200/1", popdataout, stack_empty); end
  endtask

  task automatic test_bypass;
    step(1'b1, 1'b1, 12'h5A5, 1'b0);
    checks++; if (popdataout !== 12'h5A5 || pop_valid !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL byp_data got %h pv=%b cnt=%0d want 5a5/1/0", popdataout, pop_valid, count); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL byp_flags got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 12'h400 + 12'(i), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (count !== 4'd5 || popdataout !== 12'h405 || pop_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got cnt=%0d %h pv=%b want 5/405/1", count, popdataout, pop_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || stack_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL arst_count got cnt=%0d empty=%b af=%b want 0/1/0", count, stack_empty, almost_full); end
    checks++; if (popdataout !== 12'h000 || pop_valid !== 1'b0) begin errors++; $display("FAIL arst_pop got %h pv=%b want 000/0", popdataout, pop_valid); end
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (underflow !== 1'b1 || pop_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL arst_first_pop got unf=%b pv=%b cnt=%0d want 1/0/0", underflow, pop_valid, count); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    pushenbl   = 1'b0;
    popenbl    = 1'b0;
    pushdatain = '0;
    err_clr    = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_bypass();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
